// File: rtl/oc_mem_stream_loader.sv
// oc_mem_stream_loader: packs an 8-bit byte stream little-endian into 32-bit words, writes them to on-chip memory, optional checksum readback
//   clk, reset                    : clock, asynchronous active-high reset
//   start/start_addr/byte_len/verify_en : load request (sampled in IDLE)
//   s_data/s_valid/s_ready         : byte stream in
//   mem_* (address/byteenable/chipselect/write/writedata/readdata) : Avalon-MM master to the memory
//   mem_clken, mem_reset_req       : memory enable/reset; a command is taken only when clken=1 and reset_req=0
//   busy/done/checksum/verify_ok   : status
module oc_mem_stream_loader #(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 16,
  parameter int CNT_W  = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  byte_len,
  input  logic              verify_en,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_clken,
  input  logic              mem_reset_req,
  output logic              busy,
  output logic              done,
  output logic [31:0]       checksum,
  output logic              verify_ok
);
  typedef enum logic [2:0] {IDLE, FILL, WRITE, RD_ADDR, RD_CMP, FINISH} state_t;
  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  rem;
  logic              verify_r;
  logic [1:0]        lane;
  logic [CNT_W-1:0]  wcnt, rcnt;
  logic [3:0]        last_be;
  logic [31:0]       rsum;
  logic              acc;
  logic [31:0]       new_wd, wmask, rsum_n;
  logic [3:0]        new_be;

  function automatic logic [31:0] expand(input logic [3:0] b);
    return {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
  endfunction

  // The word is packed directly in mem_writedata/mem_byteenable while chipselect is low.
  always_comb begin
    acc    = mem_clken & ~mem_reset_req;
    new_wd = mem_writedata | (32'(s_data) << {lane, 3'b000});
    new_be = mem_byteenable | (4'b0001 << lane);
    wmask  = expand(mem_byteenable);
    rsum_n = rsum + (mem_readdata & (rcnt == CNT_W'(1) ? expand(last_be) : 32'hFFFF_FFFF));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      base           <= '0;
      rem            <= '0;
      verify_r       <= 1'b0;
      lane           <= '0;
      wcnt           <= '0;
      rcnt           <= '0;
      last_be        <= '0;
      rsum           <= '0;
      s_ready        <= 1'b0;
      mem_address    <= '0;
      mem_byteenable <= '0;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      checksum       <= '0;
      verify_ok      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          base           <= start_addr;
          mem_address    <= start_addr;
          rem            <= byte_len;
          verify_r       <= verify_en;
          lane           <= '0;
          wcnt           <= '0;
          rsum           <= '0;
          mem_writedata  <= '0;
          mem_byteenable <= '0;
          checksum       <= '0;
          verify_ok      <= 1'b0;
          busy           <= 1'b1;
          if (byte_len == '0) begin
            state     <= FINISH;
            done      <= 1'b1;
            busy      <= 1'b0;
            verify_ok <= 1'b1;
          end else begin
            state   <= FILL;
            s_ready <= 1'b1;
          end
        end
        FILL: if (s_valid) begin
          mem_writedata  <= new_wd;
          mem_byteenable <= new_be;
          lane           <= lane + 2'd1;
          rem            <= rem - LEN_W'(1);
          if (lane == 2'd3 || rem == LEN_W'(1)) begin
            state          <= WRITE;
            s_ready        <= 1'b0;
            mem_chipselect <= 1'b1;
            mem_write      <= 1'b1;
          end
        end
        WRITE: if (acc) begin
          checksum    <= checksum + (mem_writedata & wmask);
          mem_address <= mem_address + ADDR_W'(1);
          wcnt        <= wcnt + CNT_W'(1);
          mem_write   <= 1'b0;
          if (rem != '0) begin
            state          <= FILL;
            s_ready        <= 1'b1;
            mem_chipselect <= 1'b0;
            mem_writedata  <= '0;
            mem_byteenable <= '0;
            lane           <= '0;
          end else if (verify_r) begin
            // wcnt still excludes the word being accepted now
            state          <= RD_ADDR;
            mem_address    <= base;
            rcnt           <= wcnt + CNT_W'(1);
            last_be        <= mem_byteenable;
            mem_byteenable <= 4'hF;
          end else begin
            state          <= FINISH;
            mem_chipselect <= 1'b0;
            done           <= 1'b1;
            busy           <= 1'b0;
            verify_ok      <= 1'b1;
          end
        end
        RD_ADDR: if (acc) begin
          state          <= RD_CMP;
          mem_chipselect <= 1'b0;
        end
        RD_CMP: begin
          rsum        <= rsum_n;
          mem_address <= mem_address + ADDR_W'(1);
          rcnt        <= rcnt - CNT_W'(1);
          if (rcnt == CNT_W'(1)) begin
            state     <= FINISH;
            done      <= 1'b1;
            busy      <= 1'b0;
            verify_ok <= rsum_n == checksum;
          end else begin
            state          <= RD_ADDR;
            mem_chipselect <= 1'b1;
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_oc_mem_stream_loader.sv
// tb_oc_mem_stream_loader: directed scoreboard bench for oc_mem_stream_loader with a byte-enabled memory model
module tb_oc_mem_stream_loader;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, verify_en = 1'b0, s_valid = 1'b0;
  logic        mem_clken = 1'b1, mem_reset_req = 1'b0;
  logic [12:0] start_addr = '0;
  logic [15:0] byte_len = '0;
  logic [7:0]  s_data = '0;
  logic        s_ready, mem_chipselect, mem_write, busy, done, verify_ok;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, checksum;
  logic [31:0] mem_readdata = '0;
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, cs_cnt = 0, t0 = 0;
  bit toggle = 1'b0;
  logic [31:0] mem [8192];
  typedef struct packed {logic [12:0] a; logic [3:0] be; logic [31:0] d;} wr_t;
  wr_t exp_q[$];
  wr_t hold, e;
  bit hold_v = 1'b0;
  logic acc;
  assign acc = mem_clken & ~mem_reset_req;

  oc_mem_stream_loader dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .byte_len(byte_len),
    .verify_en(verify_en), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_clken(mem_clken), .mem_reset_req(mem_reset_req), .busy(busy), .done(done),
    .checksum(checksum), .verify_ok(verify_ok)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // memory model: registered read, byte-enabled write, both only on accepted cycles
  always @(posedge clk) begin
    cyc++;
    if (mem_chipselect && acc && !reset) begin
      if (mem_write) begin
        for (int l = 0; l < 4; l++)
          if (mem_byteenable[l]) mem[mem_address][8*l +: 8] = mem_writedata[8*l +: 8];
      end else mem_readdata <= mem[mem_address];
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (toggle) begin
      mem_clken = ~mem_clken;
      mem_reset_req = ($urandom_range(0, 3) == 0);
    end else begin
      mem_clken = 1'b1;
      mem_reset_req = 1'b0;
    end
  end

  // write scoreboard and strobe-stability monitor
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (mem_chipselect) cs_cnt++;
    if (reset) hold_v = 1'b0;
    else begin
      if (hold_v) begin
        check("wr_held_strobe", 64'({mem_chipselect, mem_write}), 64'(2'b11));
        check("wr_held_cmd", 64'({mem_address, mem_byteenable, mem_writedata}), 64'(hold));
      end
      hold_v = 1'b0;
      if (mem_chipselect && mem_write) begin
        if (!acc) begin
          hold = {mem_address, mem_byteenable, mem_writedata};
          hold_v = 1'b1;
        end else if (exp_q.size() == 0) check("unexpected_write", 64'(exp_q.size()), 64'd1);
        else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(mem_address), 64'(e.a));
          check("wr_be", 64'(mem_byteenable), 64'(e.be));
          check("wr_data", 64'(mem_writedata), 64'(e.d));
        end
      end
    end
  end

  function automatic logic [31:0] model_sum(input logic [7:0] b[$]);
    logic [31:0] s = '0;
    for (int k = 0; k < b.size(); k++) s += 32'(b[k]) << (8 * (k % 4));
    return s;
  endfunction

  task automatic do_start(input logic [12:0] a, input int len, input bit v, input logic [7:0] b[$]);
    repeat (2) @(negedge clk);
    for (int w = 0; w * 4 < len; w++) begin
      wr_t x;
      x.a = a + 13'(w);
      x.be = '0;
      x.d = '0;
      for (int l = 0; l < 4 && w * 4 + l < len; l++) begin
        x.be[l] = 1'b1;
        x.d[8*l +: 8] = b[w*4+l];
      end
      exp_q.push_back(x);
    end
    start_addr = a;
    byte_len = 16'(len);
    verify_en = v;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] b[$]);
    for (int k = 0; k < b.size(); k++) begin
      int n = 0;
      s_data = b[k];
      s_valid = 1'b1;
      @(negedge clk);
      while (!s_ready && n < 200) begin
        n++;
        @(negedge clk);
      end
      if (n >= 200) check("feed_timeout", 64'(n), 64'd0);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    int n = 0;
    @(negedge clk);
    while (!done && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 3000) check("done_timeout", 64'(n), 64'd0);
    lat = cyc - t0;
  endtask

  initial begin
    logic [7:0] b1[$], b2[$], b3[$], b5[$], bz[$];
    int lat, dc, cs0;
    for (int i = 0; i < 8192; i++) mem[i] = '0;
    b1 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    b2 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    b3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    b5 = '{8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h99};
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_ctl", 64'({busy, done, s_ready, mem_chipselect, mem_write, verify_ok, mem_byteenable}), 64'd0);
    check("reset_data", 64'({mem_address, mem_writedata}), 64'd0);
    check("reset_sum", 64'(checksum), 64'd0);

    do_start(13'h0010, 8, 1'b1, b1);
    feed(b1);
    wait_done(lat);
    check("t1_latency", 64'(lat), 64'd15);
    check("t1_checksum", 64'(checksum), 64'h0C0A_0806);
    check("t1_verify_ok", 64'(verify_ok), 64'd1);
    check("t1_busy", 64'(busy), 64'd0);
    check("t1_all_written", 64'(exp_q.size()), 64'd0);
    check("t1_mem0", 64'(mem[16]), 64'h0403_0201);
    check("t1_mem1", 64'(mem[17]), 64'h0807_0605);

    mem[33] = 32'h1234_0000;
    do_start(13'h0020, 6, 1'b1, b2);
    feed(b2);
    s_valid = 1'b1;
    s_data = 8'h99;
    wait_done(lat);
    check("t2_excess_not_ready", 64'(s_ready), 64'd0);
    s_valid = 1'b0;
    check("t2_checksum", 64'(checksum), 64'(model_sum(b2)));
    check("t2_checksum_lit", 64'(checksum), 64'hDDCD_BB98);
    check("t2_verify_ok", 64'(verify_ok), 64'd1);
    check("t2_mem_merge", 64'(mem[33]), 64'h1234_FFEE);

    cs0 = cs_cnt;
    do_start(13'h0005, 0, 1'b1, bz);
    wait_done(lat);
    check("t3_zero_latency", 64'(lat), 64'd1);
    check("t3_zero_verify_ok", 64'(verify_ok), 64'd1);
    check("t3_zero_sum", 64'(checksum), 64'd0);
    repeat (2) @(negedge clk);
    check("t3_zero_no_cs", 64'(cs_cnt - cs0), 64'd0);

    do_start(13'h1FFF, 8, 1'b1, b3);
    feed(b3);
    wait_done(lat);
    check("t4_wrap_verify_ok", 64'(verify_ok), 64'd1);
    check("t4_wrap_checksum", 64'(checksum), 64'(model_sum(b3)));
    check("t4_mem_top", 64'(mem[8191]), 64'h4433_2211);
    check("t4_mem_zero", 64'(mem[0]), 64'h8877_6655);

    toggle = 1'b1;
    do_start(13'h0010, 8, 1'b1, b1);
    feed(b1);
    wait_done(lat);
    toggle = 1'b0;
    check("t5_toggle_checksum", 64'(checksum), 64'h0C0A_0806);
    check("t5_toggle_verify_ok", 64'(verify_ok), 64'd1);
    check("t5_toggle_all_written", 64'(exp_q.size()), 64'd0);

    do_start(13'h0040, 8, 1'b1, b3);
    feed(b3);
    begin
      int n = 0;
      @(negedge clk);
      while (!(mem_chipselect && !mem_write) && n < 200) begin
        n++;
        @(negedge clk);
      end
      if (n >= 200) check("t6_read_timeout", 64'(n), 64'd0);
    end
    mem[64] = mem[64] ^ 32'h0000_0100;
    wait_done(lat);
    check("t6_corrupt_verify_ok", 64'(verify_ok), 64'd0);
    check("t6_corrupt_checksum", 64'(checksum), 64'(model_sum(b3)));

    do_start(13'h0064, 8, 1'b1, b1);
    feed(b1[0:1]);
    reset = 1'b1;
    #1;
    check("t7_rst_ctl", 64'({busy, done, s_ready, mem_chipselect, mem_write, verify_ok, mem_byteenable}), 64'd0);
    check("t7_rst_data", 64'({mem_address, mem_writedata, checksum}), 64'd0);
    exp_q.delete();
    dc = done_cnt;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check("t7_no_done", 64'(done_cnt - dc), 64'd0);
    do_start(13'h00C8, 5, 1'b0, b5);
    feed(b5);
    wait_done(lat);
    check("t7_after_latency", 64'(lat), 64'd8);
    check("t7_after_verify_ok", 64'(verify_ok), 64'd1);
    check("t7_after_checksum", 64'(checksum), 64'(model_sum(b5)));
    check("t7_after_partial", 64'(mem[201]), 64'h0000_0099);
    check("t7_after_all_written", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
